// File: rtl/ball_engine.sv
// Ball motion engine for the 8x8 LED pong field.
// Parks the ball on the serving paddle, steps it at a fixed rate while
// playing (faster once the rally is long), bounces it off the side walls
// and the paddles, and pulses miss_p1 / miss_p2 when a paddle is missed.
module ball_engine #(
    parameter int TICK_DIV = 2500000,
    parameter int FAST_DIV = 1250000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] game_state,
    input  logic [2:0] p1_pos,
    input  logic [2:0] p2_pos,
    output logic [2:0] ball_x,
    output logic [2:0] ball_y,
    output logic       ball_dx,
    output logic       ball_dy,
    output logic       step,
    output logic [5:0] time_cnt,
    output logic       miss_p1,
    output logic       miss_p2
);

    localparam int MAX_DIV = (TICK_DIV > FAST_DIV) ? TICK_DIV : FAST_DIV;
    localparam int DIV_W   = $clog2(MAX_DIV) + 1;
    localparam logic [DIV_W-1:0] TICK_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] FAST_LAST = DIV_W'(FAST_DIV - 1);

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_last;
    logic [2:0]       p1_left;
    logic [2:0]       p2_left;
    logic [2:0]       serve_x;
    logic [2:0]       nx;
    logic [2:0]       ny;
    logic             ndx;
    logic             ndy;
    logic             miss1_hit;
    logic             miss2_hit;

    // Clamp paddles so a two-column paddle never runs off the field, and
    // pick the divider terminal count for the current rally speed.
    always_comb begin
        p1_left  = (p1_pos == 3'd7) ? 3'd6 : p1_pos;
        p2_left  = (p2_pos == 3'd7) ? 3'd6 : p2_pos;
        serve_x  = game_state[0] ? p2_left : p1_left;
        div_last = (time_cnt >= 6'd32) ? FAST_LAST : TICK_LAST;
    end

    // Next ball position for a step: x (with wall bounce) first, then y,
    // whose paddle check uses the already-updated column.
    always_comb begin
        nx        = ball_x;
        ndx       = ball_dx;
        ny        = ball_y;
        ndy       = ball_dy;
        miss1_hit = 1'b0;
        miss2_hit = 1'b0;
        if (ball_dx) begin
            if (ball_x == 3'd7) begin
                nx  = 3'd6;
                ndx = 1'b0;
            end else begin
                nx = ball_x + 3'd1;
            end
        end else begin
            if (ball_x == 3'd0) begin
                nx  = 3'd1;
                ndx = 1'b1;
            end else begin
                nx = ball_x - 3'd1;
            end
        end
        if (ball_y == 3'd1 && !ball_dy) begin
            if (nx == p1_left || nx == p1_left + 3'd1) begin
                ny  = 3'd2;
                ndy = 1'b1;
            end else begin
                ny        = 3'd0;
                miss1_hit = 1'b1;
            end
        end else if (ball_y == 3'd6 && ball_dy) begin
            if (nx == p2_left || nx == p2_left + 3'd1) begin
                ny  = 3'd5;
                ndy = 1'b0;
            end else begin
                ny        = 3'd7;
                miss2_hit = 1'b1;
            end
        end else if (ball_dy) begin
            ny = ball_y + 3'd1;
        end else begin
            ny = ball_y - 3'd1;
        end
    end

    // Game-phase FSM with the step divider and all registered ball outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= HOLD;
            div      <= '0;
            ball_x   <= 3'd3;
            ball_y   <= 3'd1;
            ball_dx  <= 1'b1;
            ball_dy  <= 1'b1;
            time_cnt <= 6'd0;
            step     <= 1'b0;
            miss_p1  <= 1'b0;
            miss_p2  <= 1'b0;
        end else begin
            step    <= 1'b0;
            miss_p1 <= 1'b0;
            miss_p2 <= 1'b0;
            if (!game_state[1]) begin
                state    <= HOLD;
                div      <= '0;
                ball_x   <= serve_x;
                ball_y   <= game_state[0] ? 3'd6 : 3'd1;
                ball_dy  <= ~game_state[0];
                ball_dx  <= (serve_x < 3'd4);
                time_cnt <= 6'd0;
            end else if (game_state == 2'd3) begin
                state <= DEAD;
                div   <= '0;
            end else begin
                case (state)
                    HOLD: begin
                        state <= RUN;
                        div   <= '0;
                    end
                    RUN: begin
                        if (div == div_last) begin
                            div      <= '0;
                            step     <= 1'b1;
                            ball_x   <= nx;
                            ball_y   <= ny;
                            ball_dx  <= ndx;
                            ball_dy  <= ndy;
                            time_cnt <= (time_cnt == 6'd63) ? 6'd63 : time_cnt + 6'd1;
                            miss_p1  <= miss1_hit;
                            miss_p2  <= miss2_hit;
                            if (miss1_hit || miss2_hit) begin
                                state <= DEAD;
                            end
                        end else begin
                            div <= div + DIV_W'(1);
                        end
                    end
                    default: begin
                        state <= DEAD;
                        div   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ball_engine.sv
// Self-checking bench for ball_engine with short divider values.
module tb_ball_engine;

    localparam int TICK = 4;
    localparam int FAST = 2;
    localparam int M_HOLD = 0;
    localparam int M_RUN  = 1;
    localparam int M_DEAD = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] game_state = 2'd0;
    logic [2:0] p1_pos = 3'd0;
    logic [2:0] p2_pos = 3'd0;
    logic [2:0] ball_x;
    logic [2:0] ball_y;
    logic       ball_dx;
    logic       ball_dy;
    logic       step;
    logic [5:0] time_cnt;
    logic       miss_p1;
    logic       miss_p2;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    int m_x, m_y, m_dx, m_dy, m_t, m_mode, m_cnt;
    bit m_step, m_m1, m_m2;
    bit track = 1'b0;

    int exp_x  [21] = '{3,4,5,6,7,6,5,4,3,2,1,0,1,2,3,4,5,6,7,6,5};
    int exp_y  [21] = '{2,3,4,5,6,5,4,3,2,1,2,3,4,5,6,5,4,3,2,1,0};
    int exp_dx [21] = '{1,1,1,1,1,0,0,0,0,0,0,0,1,1,1,1,1,1,1,0,0};
    int exp_dy [21] = '{1,1,1,1,1,0,0,0,0,0,1,1,1,1,1,0,0,0,0,0,0};
    int iv [71];

    always #5 clk = ~clk;

    ball_engine #(.TICK_DIV(TICK), .FAST_DIV(FAST)) dut (
        .clk(clk), .reset(reset), .game_state(game_state),
        .p1_pos(p1_pos), .p2_pos(p2_pos),
        .ball_x(ball_x), .ball_y(ball_y), .ball_dx(ball_dx), .ball_dy(ball_dy),
        .step(step), .time_cnt(time_cnt), .miss_p1(miss_p1), .miss_p2(miss_p2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_x = 3; m_y = 1; m_dx = 1; m_dy = 1; m_t = 0;
        m_mode = M_HOLD; m_cnt = 0; m_step = 0; m_m1 = 0; m_m2 = 0;
    endfunction

    function automatic int paddle(input int p);
        return (p == 7) ? 6 : p;
    endfunction

    // Column the ball will occupy on its next step, walls included.
    function automatic int next_col();
        int px;
        px = m_x + (m_dx != 0 ? 1 : -1);
        if (px > 7) px = 6;
        if (px < 0) px = 1;
        return px;
    endfunction

    // One ball step: arriving at a paddle row is either a return or a miss.
    function automatic void model_step();
        int px, py, pad;
        px = m_x + (m_dx != 0 ? 1 : -1);
        if (px > 7) begin px = 6; m_dx = 0; end
        else if (px < 0) begin px = 1; m_dx = 1; end
        py = m_y + (m_dy != 0 ? 1 : -1);
        if (py == 0) begin
            pad = paddle(int'(p1_pos));
            if (px - pad == 0 || px - pad == 1) begin m_y = 2; m_dy = 1; end
            else begin m_y = 0; m_m1 = 1; m_mode = M_DEAD; end
        end else if (py == 7) begin
            pad = paddle(int'(p2_pos));
            if (px - pad == 0 || px - pad == 1) begin m_y = 5; m_dy = 0; end
            else begin m_y = 7; m_m2 = 1; m_mode = M_DEAD; end
        end else begin
            m_y = py;
        end
        m_x = px;
        m_step = 1;
        m_t = (m_t + 1 > 63) ? 63 : m_t + 1;
    endfunction

    function automatic void model_clock();
        m_step = 0; m_m1 = 0; m_m2 = 0;
        if (game_state < 2) begin
            m_mode = M_HOLD;
            m_x  = paddle(game_state == 0 ? int'(p1_pos) : int'(p2_pos));
            m_y  = (game_state == 0) ? 1 : 6;
            m_dy = (game_state == 0) ? 1 : 0;
            m_dx = (m_x < 4) ? 1 : 0;
            m_t  = 0;
            m_cnt = 0;
        end else if (game_state == 3) begin
            m_mode = M_DEAD;
            m_cnt = 0;
        end else if (m_mode == M_HOLD) begin
            m_mode = M_RUN;
            m_cnt = 0;
        end else if (m_mode == M_RUN) begin
            m_cnt++;
            if (m_cnt == ((m_t >= 32) ? FAST : TICK)) begin
                m_cnt = 0;
                model_step();
            end
        end
    endfunction

    function automatic logic [16:0] model_vec();
        return {3'(m_x), 3'(m_y), 1'(m_dx), 1'(m_dy), m_step, 6'(m_t), m_m1, m_m2};
    endfunction

    task automatic applyStimulus();
        if (track) begin
            p1_pos = 3'(paddle(next_col()));
            p2_pos = 3'(paddle(next_col()));
        end
        if (reset) model_clock();
        else model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        check(tag, {ball_x, ball_y, ball_dx, ball_dy, step, time_cnt, miss_p1, miss_p2}, model_vec());
    endtask

    task automatic tick();
        applyStimulus();
        checkOutput("cycle");
    endtask

    task automatic wait_step(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!step && n < 64);
        check("step_seen", step, 1);
    endtask

    initial begin
        int n;
        int sx, sy;
        int r;
        model_reset();

        // Reset held while playing: ball parked at reset position.
        reset = 0; game_state = 2; p1_pos = 2; p2_pos = 6;
        repeat (3) tick();
        check("rst_x", ball_x, 3);
        check("rst_y", ball_y, 1);
        check("rst_step", step, 0);
        check("rst_miss", {miss_p1, miss_p2}, 0);

        // Release into P1 serve; ball tracks the paddle with clamping.
        game_state = 0;
        #2 reset = 1;
        tick();
        check("hold_x", ball_x, 2);
        check("hold_dx", ball_dx, 1);
        p1_pos = 7;
        tick();
        check("hold_clamp_x", ball_x, 6);
        check("hold_dx_left", ball_dx, 0);
        p1_pos = 2;
        tick();

        // Launch and play a directed rally ending in a P1 miss.
        game_state = 2;
        tick();
        p1_pos = 0;
        for (int k = 0; k < 21; k++) begin
            wait_step(n);
            check("interval", n, TICK);
            check("step_x", ball_x, exp_x[k]);
            check("step_y", ball_y, exp_y[k]);
            check("step_dx", ball_dx, exp_dx[k]);
            check("step_dy", ball_dy, exp_dy[k]);
            check("step_t", time_cnt, k + 1);
            if (k == 5) p2_pos = 4;
        end
        check("miss_p1_pulse", miss_p1, 1);
        check("miss_p2_quiet", miss_p2, 0);
        tick();
        check("miss_p1_done", miss_p1, 0);
        repeat (20) tick();
        check("dead_x", ball_x, 5);
        check("dead_y", ball_y, 0);
        check("dead_t", time_cnt, 21);

        // Long rally from a P2 serve: speed-up at 32 and saturation at 63.
        game_state = 1; p2_pos = 3;
        tick();
        check("p2_park", {ball_x, ball_y, ball_dx, ball_dy, time_cnt}, {3'd3, 3'd6, 1'b1, 1'b0, 6'd0});
        track = 1;
        game_state = 2;
        tick();
        for (int k = 1; k <= 70; k++) begin
            wait_step(n);
            iv[k] = n;
        end
        check("iv_first", iv[1], TICK);
        check("iv_31", iv[31], TICK);
        check("iv_32", iv[32], TICK);
        check("iv_33", iv[33], FAST);
        check("iv_50", iv[50], FAST);
        check("sat_t", time_cnt, 63);

        // Abort to end state freezes the ball, then a P2 serve re-parks it.
        repeat (2) tick();
        sx = m_x; sy = m_y;
        game_state = 3;
        repeat (12) tick();
        check("abort_x", ball_x, sx);
        check("abort_y", ball_y, sy);
        check("abort_t", time_cnt, 63);
        track = 0;
        game_state = 1; p2_pos = 5;
        tick();
        check("repark", {ball_x, ball_y, ball_dx, ball_dy, time_cnt}, {3'd5, 3'd6, 1'b0, 1'b0, 6'd0});

        // Asynchronous reset in the middle of a rally.
        track = 1;
        game_state = 2;
        tick();
        wait_step(n);
        wait_step(n);
        tick();
        #2 reset = 0;
        #1;
        model_reset();
        checkOutput("async_reset");
        check("async_xy", {ball_x, ball_y, time_cnt}, {3'd3, 3'd1, 6'd0});
        repeat (2) tick();
        reset = 1;
        track = 0;
        repeat (10) tick();

        // Randomised play against the reference model.
        for (int i = 0; i < 3000; i++) begin
            reset = 1;
            if ($urandom_range(0, 63) == 0) begin
                r = $urandom_range(0, 9);
                game_state = (r < 6) ? 2'd2 : (r < 7) ? 2'd3 : (r < 8) ? 2'd0 : 2'd1;
                track = ($urandom_range(0, 1) == 1);
            end
            if (!track) begin
                p1_pos = 3'($urandom_range(0, 7));
                p2_pos = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 499) == 0) begin
                reset = 0;
                #1;
                model_reset();
                checkOutput("rand_async_reset");
            end
            tick();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
